// File: rtl/wb_dual_mem_slave.sv
// wb_dual_mem_slave: dual-channel Wishbone classic memory slave with per-channel wait states
// Define WB_ERR_EN to add d_err for out-of-range data accesses (instruction channel always wraps)
module wb_dual_mem_slave #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int I_WAIT = 0,
    parameter int D_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cyc,
    input  logic                i_stb,
    input  logic [ADDR_W-1:0]   i_adr,
    output logic [DATA_W-1:0]   i_dat,
    output logic                i_ack,
    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_adr,
    input  logic [DATA_W-1:0]   d_wdat,
    output logic [DATA_W-1:0]   d_rdat,
`ifdef WB_ERR_EN
    output logic                d_err,
`endif
    output logic                d_ack
);
    localparam int SEL_W = DATA_W / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              i_st_q, i_st_d, d_st_q, d_st_d;
    logic [3:0]          i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic [AW-1:0]       i_idx_q, i_idx_d, d_idx_q, d_idx_d;
    logic                d_we_q, d_we_d, d_bad_q, d_bad_d;
    logic [SEL_W-1:0]    d_sel_q, d_sel_d;
    logic [DATA_W-1:0]   d_wdat_q, d_wdat_d;
    logic [DATA_W-1:0]   i_dat_q, i_dat_d, d_rdat_q, d_rdat_d;
    logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic                d_oob, d_wr, unused_ok;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef WB_ERR_EN
    assign d_oob = (d_adr >> (LSB + AW)) != '0;
    assign d_err = d_err_q;
`else
    assign d_oob = 1'b0;
`endif
    assign unused_ok = ^{i_adr, d_adr, d_err_q};

    always_comb begin
        i_st_d  = i_st_q;
        i_cnt_d = i_cnt_q;
        i_idx_d = i_idx_q;
        if (i_st_q == S_IDLE && i_cyc && i_stb) begin
            i_idx_d = i_adr[LSB +: AW];
            i_cnt_d = 4'(I_WAIT);
            i_st_d  = (I_WAIT != 0) ? S_WAIT : S_ACK;
        end else if (i_st_q == S_WAIT) begin
            i_cnt_d = i_cnt_q - 4'd1;
            i_st_d  = !i_cyc ? S_IDLE : (i_cnt_q == 4'd1) ? S_ACK : S_WAIT;
        end else if (i_st_q == S_ACK) begin
            i_st_d = S_IDLE;
        end
        i_ack_d = i_st_q == S_ACK;
        i_dat_d = i_ack_d ? mem[i_idx_q] : i_dat_q;
    end

    always_comb begin
        d_st_d   = d_st_q;
        d_cnt_d  = d_cnt_q;
        d_idx_d  = d_idx_q;
        d_we_d   = d_we_q;
        d_sel_d  = d_sel_q;
        d_wdat_d = d_wdat_q;
        d_bad_d  = d_bad_q;
        if (d_st_q == S_IDLE && d_cyc && d_stb) begin
            d_idx_d  = d_adr[LSB +: AW];
            d_we_d   = d_we;
            d_sel_d  = d_sel;
            d_wdat_d = d_wdat;
            d_bad_d  = d_oob;
            d_cnt_d  = 4'(D_WAIT);
            d_st_d   = (D_WAIT != 0) ? S_WAIT : S_ACK;
        end else if (d_st_q == S_WAIT) begin
            d_cnt_d = d_cnt_q - 4'd1;
            d_st_d  = !d_cyc ? S_IDLE : (d_cnt_q == 4'd1) ? S_ACK : S_WAIT;
        end else if (d_st_q == S_ACK) begin
            d_st_d = S_IDLE;
        end
        d_ack_d  = d_st_q == S_ACK && !d_bad_q;
        d_err_d  = d_st_q == S_ACK && d_bad_q;
        d_wr     = d_ack_d && d_we_q;
        d_rdat_d = (d_ack_d && !d_we_q) ? mem[d_idx_q] : d_rdat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_st_q   <= S_IDLE;
            i_cnt_q  <= '0;
            i_idx_q  <= '0;
            i_dat_q  <= '0;
            i_ack_q  <= 1'b0;
            d_st_q   <= S_IDLE;
            d_cnt_q  <= '0;
            d_idx_q  <= '0;
            d_we_q   <= 1'b0;
            d_sel_q  <= '0;
            d_wdat_q <= '0;
            d_bad_q  <= 1'b0;
            d_rdat_q <= '0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
        end else begin
            i_st_q   <= i_st_d;
            i_cnt_q  <= i_cnt_d;
            i_idx_q  <= i_idx_d;
            i_dat_q  <= i_dat_d;
            i_ack_q  <= i_ack_d;
            d_st_q   <= d_st_d;
            d_cnt_q  <= d_cnt_d;
            d_idx_q  <= d_idx_d;
            d_we_q   <= d_we_d;
            d_sel_q  <= d_sel_d;
            d_wdat_q <= d_wdat_d;
            d_bad_q  <= d_bad_d;
            d_rdat_q <= d_rdat_d;
            d_ack_q  <= d_ack_d;
            d_err_q  <= d_err_d;
        end
    end

    // array reads above sample the pre-edge contents, so a same-edge ifetch sees old data
    always_ff @(posedge clk) begin
        for (int k = 0; k < SEL_W; k++)
            if (d_wr && d_sel_q[k]) mem[d_idx_q][8*k +: 8] <= d_wdat_q[8*k +: 8];
    end

    assign i_dat  = i_dat_q;
    assign i_ack  = i_ack_q;
    assign d_rdat = d_rdat_q;
    assign d_ack  = d_ack_q;
endmodule

// File: tb/tb_wb_dual_mem_slave.sv
// tb_wb_dual_mem_slave: scoreboard bench for wb_dual_mem_slave (DATA_W=16, I_WAIT=0, D_WAIT=1)
module tb_wb_dual_mem_slave;
    localparam int IW = 0;
    localparam int DW = 1;

    typedef struct {
        logic        rd;
        logic        err;
        logic [15:0] dat;
    } d_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cyc = 1'b0, i_stb = 1'b0;
    logic [15:0] i_adr = '0;
    logic [15:0] i_dat;
    logic        i_ack;
    logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
    logic [1:0]  d_sel = '0;
    logic [15:0] d_adr = '0, d_wdat = '0;
    logic [15:0] d_rdat;
    logic        d_ack, d_err;
`ifndef WB_ERR_EN
    assign d_err = 1'b0;
`endif

    d_exp_t      d_q[$];
    logic [15:0] i_q[$];
    logic [15:0] mem_m [1024];
    logic [15:0] last_d = '0, last_i = '0, old;
    d_exp_t      de;
    logic [15:0] ie;
    int          vec_n = 0, bad_n = 0;

    always #5 clk = ~clk;

    wb_dual_mem_slave #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .I_WAIT(IW), .D_WAIT(DW)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_adr(i_adr), .i_dat(i_dat), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr),
        .d_wdat(d_wdat), .d_rdat(d_rdat),
`ifdef WB_ERR_EN
        .d_err(d_err),
`endif
        .d_ack(d_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] idx(input logic [15:0] a);
        return a[10:1];
    endfunction

    function automatic logic oob(input logic [15:0] a);
`ifdef WB_ERR_EN
        return a[15:11] != 5'd0;
`else
        return a[15] & 1'b0;
`endif
    endfunction

    task automatic d_issue(input logic we, input logic [1:0] sel, input logic [15:0] adr, input logic [15:0] wdat);
        d_exp_t e;
        d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_sel = sel; d_adr = adr; d_wdat = wdat;
        e.rd  = !we;
        e.err = oob(adr);
        if (!e.err && !we) last_d = mem_m[idx(adr)];
        if (!e.err && we)
            for (int k = 0; k < 2; k++)
                if (sel[k]) mem_m[idx(adr)][8*k +: 8] = wdat[8*k +: 8];
        e.dat = last_d;
        d_q.push_back(e);
    endtask

    task automatic wait_d(input int exp_n, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(d_ack || d_err) && n < 20);
        chk(tag, n, exp_n);
    endtask

    task automatic d_do(input logic we, input logic [1:0] sel, input logic [15:0] adr, input logic [15:0] wdat);
        d_issue(we, sel, adr, wdat);
        wait_d(DW + 2, "d_latency");
        d_cyc = 1'b0; d_stb = 1'b0;
    endtask

    task automatic i_issue(input logic [15:0] adr, input logic [15:0] exp);
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = adr;
        last_i = exp;
        i_q.push_back(exp);
    endtask

    task automatic wait_i(input int exp_n, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!i_ack && n < 20);
        chk(tag, n, exp_n);
    endtask

    task automatic i_do(input logic [15:0] adr);
        i_issue(adr, mem_m[idx(adr)]);
        wait_i(IW + 2, "i_latency");
        i_cyc = 1'b0; i_stb = 1'b0;
    endtask

    always @(negedge clk) begin
        if (d_ack || d_err) begin
            if (d_q.size() == 0) chk("d_spurious", 32'(d_ack | d_err), 32'd0);
            else begin
                de = d_q.pop_front();
                chk("d_err", 32'(d_err), 32'(de.err));
                chk("d_ack", 32'(d_ack), 32'(!de.err));
                chk("d_rdat", 32'(d_rdat), 32'(de.dat));
            end
        end
        if (i_ack) begin
            if (i_q.size() == 0) chk("i_spurious", 32'(i_ack), 32'd0);
            else begin
                ie = i_q.pop_front();
                chk("i_dat", 32'(i_dat), 32'(ie));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_i_dat", 32'(i_dat), 32'd0);
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_d_rdat", 32'(d_rdat), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_d_err", 32'(d_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // basic write/read on both channels
        d_do(1'b1, 2'b11, 16'h0004, 16'hBEEF);
        d_do(1'b0, 2'b11, 16'h0004, 16'h0000);
        i_do(16'h0004);
        // byte lanes, empty select, low address bit ignored
        d_do(1'b1, 2'b01, 16'h0004, 16'h1234);
        d_do(1'b0, 2'b11, 16'h0004, 16'h0000);
        d_do(1'b1, 2'b00, 16'h0004, 16'hFFFF);
        d_do(1'b0, 2'b11, 16'h0005, 16'h0000);
        // same-edge write and fetch of one word
        d_do(1'b1, 2'b11, 16'h0010, 16'h0000);
        old = mem_m[idx(16'h0010)];
        d_issue(1'b1, 2'b11, 16'h0010, 16'hAAAA);
        @(negedge clk);
        i_issue(16'h0010, old);
        wait_i(IW + 2, "coll_i_latency");
        chk("coll_same_edge", 32'(d_ack), 32'd1);
        d_cyc = 1'b0; d_stb = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        i_do(16'h0010);
        // abort by dropping cyc in WAIT
        d_do(1'b1, 2'b11, 16'h0020, 16'h1111);
        d_do(1'b0, 2'b11, 16'h0020, 16'h0000);
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 2'b11; d_adr = 16'h0020; d_wdat = 16'h5555;
        @(negedge clk);
        d_cyc = 1'b0; d_stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(d_ack), 32'd0);
        end
        d_do(1'b0, 2'b11, 16'h0020, 16'h0000);
        // reset pulse in WAIT
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 2'b11; d_adr = 16'h0020; d_wdat = 16'h5555;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_i_dat", 32'(i_dat), 32'd0);
        chk("mid_rst_d_rdat", 32'(d_rdat), 32'd0);
        chk("mid_rst_d_ack", 32'(d_ack), 32'd0);
        chk("mid_rst_i_ack", 32'(i_ack), 32'd0);
        chk("mid_rst_d_err", 32'(d_err), 32'd0);
        d_cyc = 1'b0; d_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_d = '0;
        last_i = '0;
        @(negedge clk);
        d_do(1'b0, 2'b11, 16'h0020, 16'h0000);
        // out-of-range data access: alias or error; fetch always wraps
        d_do(1'b1, 2'b11, 16'h0000, 16'h0F0F);
        d_do(1'b1, 2'b11, 16'h0800, 16'hC0DE);
        d_do(1'b0, 2'b11, 16'h0000, 16'h0000);
        i_do(16'h0800);
        // streaming with stb held high
        for (int k = 0; k < 8; k++) d_do(1'b1, 2'b11, 16'(16'h0040 + 2 * k), 16'(16'h1111 * k + 16'h0102));
        for (int k = 0; k < 8; k++) begin
            d_issue(1'b0, 2'b11, 16'(16'h0040 + 2 * k), 16'h0000);
            wait_d(DW + 2, "d_stream_gap");
        end
        d_cyc = 1'b0; d_stb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_issue(16'(16'h0040 + 2 * k), mem_m[idx(16'(16'h0040 + 2 * k))]);
            wait_i(IW + 2, "i_stream_gap");
        end
        i_cyc = 1'b0; i_stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("d_q_drained", d_q.size(), 32'd0);
        chk("i_q_drained", i_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
        $finish;
    end
endmodule
